// File: rtl/conv_window_gen.sv
// Sliding KxK window generator over a row-major pixel stream.
// K-1 cascaded line buffers feed a shifting KxK register window.
module conv_window_gen #(
  parameter int EXP   = 8,
  parameter int MANT  = 7,
  parameter int WIDTH = 1 + EXP + MANT,
  parameter int K     = 3,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                          clock,
  input  logic                          clock_areset_n,
  input  logic                          pixel_valid,
  input  logic                          pixel_sof,
  input  logic [WIDTH-1:0]              pixel,
  output logic                          window_valid,
  output logic [K*K-1:0][WIDTH-1:0]     window,
  output logic [$clog2(IMG_H)-1:0]      window_row,
  output logic [$clog2(IMG_W)-1:0]      window_col,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int N  = K * K;

  logic [CW-1:0]          col_q;
  logic [RW-1:0]          row_q;
  logic [CW-1:0]          pc;
  logic [RW-1:0]          pr;
  logic                   last_col;
  logic                   last_row;
  logic                   hit;
  logic [WIDTH-1:0]       lb [K-1][IMG_W];
  logic [WIDTH-1:0]       tap [K-1];
  logic [N-1:0][WIDTH-1:0] win_q;
  logic [N-1:0][WIDTH-1:0] win_d;

  // Effective position of this pixel; sof forces (0,0).
  always_comb begin
    pc       = pixel_sof ? '0 : col_q;
    pr       = pixel_sof ? '0 : row_q;
    last_col = (pc == CW'(IMG_W - 1));
    last_row = (pr == RW'(IMG_H - 1));
    hit      = (pr >= RW'(K - 1)) && (pc >= CW'(K - 1));
  end

  // Line-buffer read at the current column (rows r-1 .. r-K+1).
  always_comb begin
    for (int i = 0; i < K - 1; i++) begin
      tap[i] = lb[i][pc];
    end
  end

  // Next window: shift left, append new column, oldest row on top.
  always_comb begin
    win_d = '0;
    for (int rr = 0; rr < K; rr++) begin
      for (int cc = 0; cc < K; cc++) begin
        if (cc < K - 1) begin
          win_d[rr*K+cc] = win_q[rr*K+cc+1];
        end else if (rr == K - 1) begin
          win_d[rr*K+cc] = pixel;
        end else begin
          win_d[rr*K+cc] = tap[K-2-rr];
        end
      end
    end
  end

  // Cascade write: pixel into newest buffer, each word moves one older.
  always_ff @(posedge clock) begin
    if (pixel_valid) begin
      lb[0][pc] <= pixel;
      for (int i = 1; i < K - 1; i++) begin
        lb[i][pc] <= tap[i-1];
      end
    end
  end

  // Raster position counters.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pixel_valid) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : pr + 1'b1;
      end else begin
        col_q <= pc + 1'b1;
        row_q <= pr;
      end
    end
  end

  // Shifting KxK register window.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      win_q <= '0;
    end else if (pixel_valid) begin
      win_q <= win_d;
    end
  end

  // Registered window outputs and frame-end pulse.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      window       <= '0;
      window_row   <= '0;
      window_col   <= '0;
    end else begin
      window_valid <= pixel_valid && hit;
      frame_done   <= pixel_valid && last_col && last_row;
      if (pixel_valid && hit) begin
        window     <= win_d;
        window_row <= pr - RW'(K - 1);
        window_col <= pc - CW'(K - 1);
      end
    end
  end

endmodule
